// File: rtl/fb_fill_engine_if.sv
// Command and framebuffer-write bundle for the rectangle fill engine.
// master = command source / framebuffer side, slave = fill engine.
interface fb_fill_engine_if #(
    parameter int RESOLUTION_X   = 400,
    parameter int RESOLUTION_Y   = 300,
    parameter int PALETTE_LENGTH = 256
);
    localparam int X_BITS = $clog2(RESOLUTION_X);
    localparam int Y_BITS = $clog2(RESOLUTION_Y);
    localparam int W_BITS = $clog2(RESOLUTION_X + 1);
    localparam int H_BITS = $clog2(RESOLUTION_Y + 1);
    localparam int I_BITS = $clog2(PALETTE_LENGTH);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [X_BITS-1:0] cmd_x0;
    logic [Y_BITS-1:0] cmd_y0;
    logic [W_BITS-1:0] cmd_w;
    logic [H_BITS-1:0] cmd_h;
    logic [I_BITS-1:0] cmd_index;
    logic [31:0]       cmd_pattern;
    logic              busy;
    logic              done;
    logic [X_BITS-1:0] fb_wr_x;
    logic [Y_BITS-1:0] fb_wr_y;
    logic [I_BITS-1:0] fb_wr_index;
    logic              fb_wr_en;
    logic              fb_wr_ready;

    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_index, cmd_pattern, fb_wr_ready,
        input  cmd_ready, busy, done, fb_wr_x, fb_wr_y, fb_wr_index, fb_wr_en
    );

    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_index, cmd_pattern, fb_wr_ready,
        output cmd_ready, busy, done, fb_wr_x, fb_wr_y, fb_wr_index, fb_wr_en
    );
endinterface

// File: rtl/fb_fill_engine.sv
// Rectangle fill: one clipped, raster-ordered framebuffer write per cycle; optional stipple via FB_FILL_PATTERN_EN.
// Latency: first write 2 cycles after command accept, done 2+N cycles after accept (N = clipped area).
// Backpressure: a presented write holds stable until fb_wr_ready; commands accepted only while idle.
module fb_fill_engine #(
    parameter int RESOLUTION_X   = 400,
    parameter int RESOLUTION_Y   = 300,
    parameter int PALETTE_LENGTH = 256
) (
    input  logic            clk,
    input  logic            reset,
    fb_fill_engine_if.slave bus
);
    localparam int X_BITS = $clog2(RESOLUTION_X);
    localparam int Y_BITS = $clog2(RESOLUTION_Y);
    localparam int W_BITS = $clog2(RESOLUTION_X + 1);
    localparam int H_BITS = $clog2(RESOLUTION_Y + 1);
    localparam int I_BITS = $clog2(PALETTE_LENGTH);
    localparam int WS     = W_BITS + 1;
    localparam int HS     = H_BITS + 1;

    typedef enum logic [1:0] {IDLE, CLIP, FILL, DONE} state_t;

    state_t            state_q;
    logic [X_BITS-1:0] x0_q, x_q;
    logic [Y_BITS-1:0] y0_q, y_q;
    logic [W_BITS-1:0] w_q, x_end_q;
    logic [H_BITS-1:0] h_q, y_end_q;
    logic [I_BITS-1:0] idx_q;
    logic              cmd_ready_q, busy_q, done_q, wr_en_q;

    logic [WS-1:0]     x_sum_d;
    logic [HS-1:0]     y_sum_d;
    logic [W_BITS-1:0] x_end_d;
    logic [H_BITS-1:0] y_end_d;
    logic              empty_d, x_last_d, y_last_d, advance_d, on_first_d, on_next_d;
    logic [X_BITS-1:0] x_nxt_d;
    logic [Y_BITS-1:0] y_nxt_d;

`ifdef FB_FILL_PATTERN_EN
    logic [31:0] pat_q;
`else
    logic unused_pattern;
    assign unused_pattern = ^bus.cmd_pattern;
`endif

    always_comb begin
        // Extra bit on the sums so x0+w / y0+h never wrap before clipping.
        x_sum_d   = WS'(x0_q) + WS'(w_q);
        y_sum_d   = HS'(y0_q) + HS'(h_q);
        x_end_d   = (x_sum_d > WS'(RESOLUTION_X)) ? W_BITS'(RESOLUTION_X) : x_sum_d[W_BITS-1:0];
        y_end_d   = (y_sum_d > HS'(RESOLUTION_Y)) ? H_BITS'(RESOLUTION_Y) : y_sum_d[H_BITS-1:0];
        empty_d   = (w_q == '0) || (h_q == '0) ||
                    (WS'(x0_q) >= WS'(RESOLUTION_X)) || (HS'(y0_q) >= HS'(RESOLUTION_Y));
        x_last_d  = (WS'(x_q) + WS'(1)) == WS'(x_end_q);
        y_last_d  = (HS'(y_q) + HS'(1)) == HS'(y_end_q);
        x_nxt_d   = x_last_d ? x0_q : x_q + X_BITS'(1);
        y_nxt_d   = x_last_d ? y_q + Y_BITS'(1) : y_q;
        // Masked pixels (wr_en low) step on without waiting for the framebuffer.
        advance_d = !wr_en_q || bus.fb_wr_ready;
`ifdef FB_FILL_PATTERN_EN
        on_first_d = pat_q[{y0_q[1:0], x0_q[2:0]}];
        on_next_d  = pat_q[{y_nxt_d[1:0], x_nxt_d[2:0]}];
`else
        on_first_d = 1'b1;
        on_next_d  = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            idx_q       <= '0;
            x0_q        <= '0;
            y0_q        <= '0;
            w_q         <= '0;
            h_q         <= '0;
            x_end_q     <= '0;
            y_end_q     <= '0;
`ifdef FB_FILL_PATTERN_EN
            pat_q       <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        x0_q        <= bus.cmd_x0;
                        y0_q        <= bus.cmd_y0;
                        w_q         <= bus.cmd_w;
                        h_q         <= bus.cmd_h;
                        idx_q       <= bus.cmd_index;
`ifdef FB_FILL_PATTERN_EN
                        pat_q       <= bus.cmd_pattern;
`endif
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= CLIP;
                    end
                end
                CLIP: begin
                    x_end_q <= x_end_d;
                    y_end_q <= y_end_d;
                    if (empty_d) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        x_q     <= x0_q;
                        y_q     <= y0_q;
                        wr_en_q <= on_first_d;
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    if (advance_d) begin
                        if (x_last_d && y_last_d) begin
                            wr_en_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            x_q     <= x_nxt_d;
                            y_q     <= y_nxt_d;
                            wr_en_q <= on_next_d;
                        end
                    end
                end
                DONE: begin
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.fb_wr_x     = x_q;
    assign bus.fb_wr_y     = y_q;
    assign bus.fb_wr_index = idx_q;
    assign bus.fb_wr_en    = wr_en_q;
endmodule

// File: tb/tb_fb_fill_engine.sv
// Directed bench for fb_fill_engine: table of fill commands plus stall, reset-abort and stipple sequences.
module tb_fb_fill_engine;
    localparam int RX = 400;
    localparam int RY = 300;
    localparam int PL = 256;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fb_fill_engine_if #(.RESOLUTION_X(RX), .RESOLUTION_Y(RY), .PALETTE_LENGTH(PL)) bus ();

    fb_fill_engine #(.RESOLUTION_X(RX), .RESOLUTION_Y(RY), .PALETTE_LENGTH(PL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [8:0] x;
        logic [8:0] y;
        logic [7:0] idx;
    } wr_t;

    typedef struct {
        int x0, y0, w, h, idx;
        int n, xe, ye, dl;
    } vec_t;

    int   vecs = 0;
    int   miss = 0;
    int   oob  = 0;
    wr_t  wr_q[$];
    int   first_rel, done_rel, done_cnt, busy_bad, en_probe, stall_k, stall_len;
    logic [8:0] probe_x, probe_y;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.fb_wr_en === 1'b1 && (bus.fb_wr_x >= 9'(RX) || bus.fb_wr_y >= 9'(RY)))
            oob++;
    end

    // Called at a sample point (#1 after a posedge); returns one sample after the accepting edge.
    task automatic issue(input int x0, input int y0, input int w, input int h,
                         input int idx, input logic [31:0] pat);
        int k;
        k = 0;
        while (bus.cmd_ready !== 1'b1 && k < 20) begin
            @(posedge clk); #1; k++;
        end
        check("cmd_ready_before_issue", bus.cmd_ready, 1);
        bus.cmd_x0      = 9'(x0);
        bus.cmd_y0      = 9'(y0);
        bus.cmd_w       = 9'(w);
        bus.cmd_h       = 9'(h);
        bus.cmd_index   = 8'(idx);
        bus.cmd_pattern = pat;
        bus.cmd_valid   = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid   = 1'b0;
    endtask

    // Sample k after issue() is cycle T+k relative to the accept cycle T.
    task automatic observe();
        int rel, stalled;
        rel = 1; stalled = 0;
        wr_q.delete();
        first_rel = -1; done_rel = -1; done_cnt = 0; busy_bad = 0; en_probe = 0;
        for (int cyc = 0; cyc < 3000 && done_rel < 0; cyc++) begin
            if (bus.busy !== 1'b1) busy_bad++;
            if (bus.done === 1'b1) begin
                done_rel = rel;
                done_cnt++;
            end
            bus.fb_wr_ready = 1'b1;
            if (bus.fb_wr_en === 1'b1) begin
                if (first_rel < 0) first_rel = rel;
                if (bus.fb_wr_x == probe_x && bus.fb_wr_y == probe_y) en_probe++;
                if (wr_q.size() == stall_k && stalled < stall_len) begin
                    bus.fb_wr_ready = 1'b0;
                    stalled++;
                end else begin
                    wr_q.push_back({bus.fb_wr_x, bus.fb_wr_y, bus.fb_wr_index});
                end
            end
            @(posedge clk); #1;
            rel++;
        end
        bus.fb_wr_ready = 1'b1;
        check("done_seen", (done_rel >= 0) ? 1 : 0, 1);
        check("busy_through_done", busy_bad, 0);
        check("done_after_pulse", bus.done, 0);
        check("cmd_ready_after_done", bus.cmd_ready, 1);
        check("busy_after_done", bus.busy, 0);
    endtask

    vec_t tbl[8];
    wr_t  exp6[4];

    initial begin
        int ex, ey, errs, acc;

        tbl[0] = '{10, 20, 3, 2, 'h5A, 6, 13, 22, 8};
        tbl[1] = '{398, 299, 5, 4, 'h11, 2, 400, 300, 4};
        tbl[2] = '{10, 20, 0, 5, 'h22, 0, 10, 25, 2};
        tbl[3] = '{400, 0, 4, 4, 'h33, 0, 0, 0, 2};
        tbl[4] = '{0, 300, 2, 2, 'h44, 0, 0, 0, 2};
        tbl[5] = '{0, 0, 400, 1, 'hFF, 400, 400, 1, 402};
        tbl[6] = '{395, 297, 5, 3, 'h0F, 15, 400, 300, 17};
        tbl[7] = '{100, 5, 511, 1, 'h80, 300, 400, 6, 302};

        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_x0 = '0; bus.cmd_y0 = '0; bus.cmd_w = '0; bus.cmd_h = '0;
        bus.cmd_index = '0; bus.cmd_pattern = '0; bus.fb_wr_ready = 1'b1;
        stall_k = -1; stall_len = 0; probe_x = 9'h1FF; probe_y = 9'h1FF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_wr_en", bus.fb_wr_en, 0);
        check("rst_wr_x", bus.fb_wr_x, 0);
        check("rst_wr_y", bus.fb_wr_y, 0);
        check("rst_wr_index", bus.fb_wr_index, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            issue(tbl[i].x0, tbl[i].y0, tbl[i].w, tbl[i].h, tbl[i].idx, 32'hFFFF_FFFF);
            observe();
            check($sformatf("v%0d_writes", i), wr_q.size(), tbl[i].n);
            check($sformatf("v%0d_done_cycle", i), done_rel, tbl[i].dl);
            check($sformatf("v%0d_done_pulses", i), done_cnt, 1);
            if (tbl[i].n > 0) check($sformatf("v%0d_first_write_cycle", i), first_rel, 2);
            ex = tbl[i].x0; ey = tbl[i].y0; errs = 0;
            foreach (wr_q[j]) begin
                if (wr_q[j].x != 9'(ex) || wr_q[j].y != 9'(ey) || wr_q[j].idx != 8'(tbl[i].idx)) errs++;
                ex++;
                if (ex == tbl[i].xe) begin
                    ex = tbl[i].x0;
                    ey++;
                end
            end
            check($sformatf("v%0d_raster_errors", i), errs, 0);
        end

        // Framebuffer stalls 3 cycles on the second pixel of a 4x1 fill.
        stall_k = 1; stall_len = 3; probe_x = 9'd51; probe_y = 9'd60;
        issue(50, 60, 4, 1, 'h77, 32'hFFFF_FFFF);
        observe();
        check("stall_writes", wr_q.size(), 4);
        check("stall_held_cycles", en_probe, 4);
        check("stall_done_cycle", done_rel, 9);
        check("stall_second_x", (wr_q.size() > 1) ? wr_q[1].x : 9'h1FF, 51);
        check("stall_third_x", (wr_q.size() > 2) ? wr_q[2].x : 9'h1FF, 52);
        stall_k = -1; stall_len = 0; probe_x = 9'h1FF; probe_y = 9'h1FF;

        // Reset while the third write of a 10x10 fill is presented.
        issue(10, 10, 10, 10, 'h33, 32'hFFFF_FFFF);
        acc = 0;
        for (int cyc = 0; cyc < 50 && reset == 1'b0; cyc++) begin
            if (bus.fb_wr_en === 1'b1) begin
                if (acc == 2) reset = 1'b1;
                acc++;
            end
            if (reset == 1'b0) begin
                @(posedge clk); #1;
            end
        end
        check("abort_reached_third_write", reset, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_wr_en", bus.fb_wr_en, 0);
        check("abort_cmd_ready", bus.cmd_ready, 1);
        check("abort_busy", bus.busy, 0);
        errs = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.done !== 1'b0 || bus.fb_wr_en !== 1'b0) errs++;
            @(posedge clk); #1;
        end
        check("abort_quiet_after", errs, 0);
        issue(7, 8, 1, 1, 'h9C, 32'hFFFF_FFFF);
        observe();
        check("after_abort_writes", wr_q.size(), 1);
        check("after_abort_done_cycle", done_rel, 3);
        check("after_abort_pixel", (wr_q.size() > 0) ? 32'(wr_q[0]) : 32'hFFFF_FFFF,
              32'({9'd7, 9'd8, 8'h9C}));

`ifdef FB_FILL_PATTERN_EN
        exp6[0] = {9'd0, 9'd0, 8'h44};
        exp6[1] = {9'd2, 9'd0, 8'h44};
        exp6[2] = {9'd4, 9'd0, 8'h44};
        exp6[3] = {9'd6, 9'd0, 8'h44};
        issue(0, 0, 8, 4, 'h44, 32'h0000_0055);
        observe();
        check("pat_writes", wr_q.size(), 4);
        check("pat_done_cycle", done_rel, 34);
        check("pat_first_write_cycle", first_rel, 2);
        errs = 0;
        foreach (wr_q[j]) if (j < 4 && wr_q[j] != exp6[j]) errs++;
        check("pat_pixel_errors", errs, 0);
`else
        exp6[0] = '0; exp6[1] = '0; exp6[2] = '0; exp6[3] = '0;
`endif

        check("out_of_bounds_writes", oob, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
